// File: rtl/riscv_pkg.sv
// Shared definitions for the program loader: FSM state encodings and default I-memory depth.
package riscv_pkg;

    localparam int PL_DEPTH_DEFAULT = 1024;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR0 = 3'd1,
        S_HDR1 = 3'd2,
        S_DATA = 3'd3,
        S_WR   = 3'd4,
        S_RUN  = 3'd5,
        S_ERR  = 3'd6
    } loader_state_t;

endpackage

// File: rtl/prog_word_asm.sv
// Little-endian byte-lane assembler: shifts bytes in from the top so the first byte
// lands in bits 7:0 once four bytes have been taken.
module prog_word_asm (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        clr,
    input  logic        byte_vld,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_rdy
);

    logic [1:0]  lane_q, lane_d;
    logic [31:0] shreg_q, shreg_d;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            lane_q  <= 2'd0;
            shreg_q <= 32'd0;
        end else begin
            lane_q  <= lane_d;
            shreg_q <= shreg_d;
        end
    end

    always_comb begin
        lane_d  = lane_q;
        shreg_d = shreg_q;
        if (clr) begin
            lane_d = 2'd0;
        end else if (byte_vld) begin
            shreg_d = {byte_in, shreg_q[31:8]};
            lane_d  = lane_q + 2'd1;
        end
    end

    // Asserted on the transfer that completes the word, so the FSM can enter WR next cycle.
    assign word_rdy = byte_vld && !clr && (lane_q == 2'd3);
    assign word     = shreg_q;

endmodule

// File: rtl/prog_loader.sv
// Streams a length-prefixed program into I-memory, then releases the core and hands
// the memory port over to its instruction fetch.
//
// state | meaning
// IDLE  | waiting for START
// HDR0  | taking word count low byte
// HDR1  | taking word count high byte, range check
// DATA  | assembling a word from four bytes
// WR    | single-cycle I-memory write
// RUN   | core out of reset, owns the memory port (terminal)
// ERR   | count exceeded DEPTH (terminal until reset)
module prog_loader
    import riscv_pkg::*;
#(
    parameter int DEPTH = PL_DEPTH_DEFAULT
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        START,
    input  logic        IN_VALID,
    input  logic [7:0]  IN_DATA,
    output logic        IN_READY,
    input  logic        CORE_I_MEM_CSN,
    input  logic [11:0] CORE_I_MEM_ADDR,
    output logic        I_MEM_CSN,
    output logic        I_MEM_WEN,
    output logic [3:0]  I_MEM_BE,
    output logic [11:0] I_MEM_ADDR,
    output logic [31:0] I_MEM_DOUT,
    output logic        CORE_RSTn,
    output logic        DONE,
    output logic        ERR
);

    loader_state_t state_q, state_d;
    logic [15:0]   count_q, count_d;
    logic [15:0]   index_q, index_d;
    logic [15:0]   hdr_count;
    logic          asm_clr;
    logic          asm_vld;
    logic [31:0]   asm_word;
    logic          asm_rdy;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= S_IDLE;
            count_q <= 16'd0;
            index_q <= 16'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            index_q <= index_d;
        end
    end

    assign hdr_count = {IN_DATA, count_q[7:0]};
    assign asm_vld   = (state_q == S_DATA) && IN_VALID;

    prog_word_asm u_word_asm (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .clr      (asm_clr),
        .byte_vld (asm_vld),
        .byte_in  (IN_DATA),
        .word     (asm_word),
        .word_rdy (asm_rdy)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        index_d    = index_q;
        asm_clr    = 1'b0;
        IN_READY   = 1'b0;
        I_MEM_CSN  = 1'b1;
        I_MEM_WEN  = 1'b1;
        I_MEM_BE   = 4'b0000;
        I_MEM_ADDR = 12'd0;
        I_MEM_DOUT = 32'd0;
        CORE_RSTn  = 1'b0;
        DONE       = 1'b0;
        ERR        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START) state_d = S_HDR0;
            end
            S_HDR0: begin
                IN_READY = 1'b1;
                if (IN_VALID) begin
                    count_d[7:0] = IN_DATA;
                    state_d      = S_HDR1;
                end
            end
            S_HDR1: begin
                IN_READY = 1'b1;
                if (IN_VALID) begin
                    count_d[15:8] = IN_DATA;
                    if (hdr_count == 16'd0) begin
                        state_d = S_RUN;
                    end else if (32'(hdr_count) > DEPTH) begin
                        state_d = S_ERR;
                    end else begin
                        index_d = 16'd0;
                        asm_clr = 1'b1;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                IN_READY = 1'b1;
                if (asm_rdy) state_d = S_WR;
            end
            S_WR: begin
                I_MEM_CSN  = 1'b0;
                I_MEM_WEN  = 1'b0;
                I_MEM_BE   = 4'b1111;
                I_MEM_ADDR = {index_q[9:0], 2'b00};
                I_MEM_DOUT = asm_word;
                index_d    = index_q + 16'd1;
                state_d    = (index_q == count_q - 16'd1) ? S_RUN : S_DATA;
            end
            S_RUN: begin
                I_MEM_CSN  = CORE_I_MEM_CSN;
                I_MEM_ADDR = CORE_I_MEM_ADDR;
                CORE_RSTn  = 1'b1;
                DONE       = 1'b1;
            end
            S_ERR: begin
                ERR = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: header handling, word assembly, timing, error and reset abort.
module tb_prog_loader;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        START = 1'b0;
    logic        IN_VALID = 1'b0;
    logic [7:0]  IN_DATA = 8'd0;
    logic        IN_READY;
    logic        CORE_I_MEM_CSN = 1'b1;
    logic [11:0] CORE_I_MEM_ADDR = 12'd0;
    logic        I_MEM_CSN;
    logic        I_MEM_WEN;
    logic [3:0]  I_MEM_BE;
    logic [11:0] I_MEM_ADDR;
    logic [31:0] I_MEM_DOUT;
    logic        CORE_RSTn;
    logic        DONE;
    logic        ERR;

    int n_pass = 0;
    int n_total = 0;

    logic [7:0]  stim[$];
    logic [11:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [3:0]  wr_be[$];

    prog_loader #(.DEPTH(1024)) dut (
        .CLK             (CLK),
        .RSTn            (RSTn),
        .START           (START),
        .IN_VALID        (IN_VALID),
        .IN_DATA         (IN_DATA),
        .IN_READY        (IN_READY),
        .CORE_I_MEM_CSN  (CORE_I_MEM_CSN),
        .CORE_I_MEM_ADDR (CORE_I_MEM_ADDR),
        .I_MEM_CSN       (I_MEM_CSN),
        .I_MEM_WEN       (I_MEM_WEN),
        .I_MEM_BE        (I_MEM_BE),
        .I_MEM_ADDR      (I_MEM_ADDR),
        .I_MEM_DOUT      (I_MEM_DOUT),
        .CORE_RSTn       (CORE_RSTn),
        .DONE            (DONE),
        .ERR             (ERR)
    );

    always #5 CLK = ~CLK;

    // Write strobes are captured mid-cycle, one record per WR cycle.
    always @(negedge CLK) begin
        if (!I_MEM_CSN && !I_MEM_WEN) begin
            wr_addr.push_back(I_MEM_ADDR);
            wr_data.push_back(I_MEM_DOUT);
            wr_be.push_back(I_MEM_BE);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RSTn = 1'b0;
        START = 1'b0;
        IN_VALID = 1'b0;
        tick();
        tick();
        RSTn = 1'b1;
        tick();
        wr_addr.delete();
        wr_data.delete();
        wr_be.delete();
    endtask

    task automatic pulse_start();
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    // Feeds stim; returns edges taken until DONE or ERR (or max_edges) and bytes consumed.
    task automatic run_stream(input bit toggle, input int max_edges,
                              output int edges, output int pos);
        bit take;
        edges = 0;
        pos = 0;
        while (edges < max_edges) begin
            if (pos < stim.size()) begin
                IN_VALID = toggle ? ((edges % 2) == 0) : 1'b1;
                IN_DATA  = stim[pos];
            end else begin
                IN_VALID = 1'b0;
            end
            take = IN_VALID && IN_READY;
            tick();
            edges++;
            if (take) pos++;
            if (DONE || ERR) break;
        end
        IN_VALID = 1'b0;
    endtask

    task automatic test_reset();
        RSTn = 1'b0;
        tick();
        tick();
        n_total++; if (IN_READY !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", IN_READY); else n_pass++;
        n_total++; if (I_MEM_CSN !== 1'b1) $display("FAIL rst_csn: got %b want 1", I_MEM_CSN); else n_pass++;
        n_total++; if (I_MEM_WEN !== 1'b1) $display("FAIL rst_wen: got %b want 1", I_MEM_WEN); else n_pass++;
        n_total++; if (I_MEM_BE !== 4'h0) $display("FAIL rst_be: got %h want 0", I_MEM_BE); else n_pass++;
        n_total++; if (I_MEM_ADDR !== 12'h0) $display("FAIL rst_addr: got %h want 0", I_MEM_ADDR); else n_pass++;
        n_total++; if (I_MEM_DOUT !== 32'h0) $display("FAIL rst_dout: got %h want 0", I_MEM_DOUT); else n_pass++;
        n_total++; if ({CORE_RSTn, DONE, ERR} !== 3'b000) $display("FAIL rst_core_done_err: got %b want 000", {CORE_RSTn, DONE, ERR}); else n_pass++;
        RSTn = 1'b1;
        IN_VALID = 1'b1;
        IN_DATA = 8'h55;
        tick();
        tick();
        n_total++; if (IN_READY !== 1'b0) $display("FAIL idle_no_ready: got %b want 0", IN_READY); else n_pass++;
        IN_VALID = 1'b0;
    endtask

    task automatic test_two_words();
        int edges, pos;
        do_reset();
        stim = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
        pulse_start();
        run_stream(1'b0, 40, edges, pos);
        n_total++; if (edges !== 12) $display("FAIL two_run_edge: got %0d want 12", edges); else n_pass++;
        n_total++; if (wr_data.size() !== 2) $display("FAIL two_wr_count: got %0d want 2", wr_data.size()); else n_pass++;
        if (wr_data.size() == 2) begin
            n_total++; if (wr_addr[0] !== 12'h000) $display("FAIL two_addr0: got %h want 000", wr_addr[0]); else n_pass++;
            n_total++; if (wr_data[0] !== 32'h00500513) $display("FAIL two_data0: got %h want 00500513", wr_data[0]); else n_pass++;
            n_total++; if (wr_addr[1] !== 12'h004) $display("FAIL two_addr1: got %h want 004", wr_addr[1]); else n_pass++;
            n_total++; if (wr_data[1] !== 32'h00A00593) $display("FAIL two_data1: got %h want 00a00593", wr_data[1]); else n_pass++;
            n_total++; if (wr_be[0] !== 4'hF) $display("FAIL two_be0: got %h want f", wr_be[0]); else n_pass++;
        end
        n_total++; if ({CORE_RSTn, DONE, IN_READY} !== 3'b110) $display("FAIL two_run_outs: got %b want 110", {CORE_RSTn, DONE, IN_READY}); else n_pass++;
        n_total++; if (pos !== 10) $display("FAIL two_bytes_used: got %0d want 10", pos); else n_pass++;
    endtask

    task automatic test_zero_count();
        int edges, pos;
        do_reset();
        stim = '{8'h00, 8'h00};
        pulse_start();
        run_stream(1'b0, 20, edges, pos);
        n_total++; if (edges !== 2) $display("FAIL zero_run_edge: got %0d want 2", edges); else n_pass++;
        n_total++; if (DONE !== 1'b1) $display("FAIL zero_done: got %b want 1", DONE); else n_pass++;
        n_total++; if (wr_data.size() !== 0) $display("FAIL zero_no_write: got %0d want 0", wr_data.size()); else n_pass++;
    endtask

    task automatic test_overflow();
        int edges, pos;
        do_reset();
        stim = '{8'h01, 8'h04};
        pulse_start();
        run_stream(1'b0, 20, edges, pos);
        n_total++; if (ERR !== 1'b1) $display("FAIL ovf_err: got %b want 1", ERR); else n_pass++;
        n_total++; if (edges !== 2) $display("FAIL ovf_edge: got %0d want 2", edges); else n_pass++;
        pulse_start();
        IN_VALID = 1'b1;
        tick();
        tick();
        n_total++; if ({ERR, IN_READY, CORE_RSTn, DONE} !== 4'b1000) $display("FAIL ovf_sticky: got %b want 1000", {ERR, IN_READY, CORE_RSTn, DONE}); else n_pass++;
        n_total++; if (I_MEM_CSN !== 1'b1) $display("FAIL ovf_mem_idle: got %b want 1", I_MEM_CSN); else n_pass++;
        n_total++; if (wr_data.size() !== 0) $display("FAIL ovf_no_write: got %0d want 0", wr_data.size()); else n_pass++;
        IN_VALID = 1'b0;
    endtask

    task automatic test_toggle_valid();
        int edges, pos;
        do_reset();
        stim = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        pulse_start();
        run_stream(1'b1, 40, edges, pos);
        n_total++; if (wr_data.size() !== 1) $display("FAIL tog_wr_count: got %0d want 1", wr_data.size()); else n_pass++;
        if (wr_data.size() == 1) begin
            n_total++; if (wr_data[0] !== 32'hDDCCBBAA) $display("FAIL tog_data: got %h want ddccbbaa", wr_data[0]); else n_pass++;
            n_total++; if (wr_addr[0] !== 12'h000) $display("FAIL tog_addr: got %h want 000", wr_addr[0]); else n_pass++;
        end
        n_total++; if (pos !== 6) $display("FAIL tog_bytes_used: got %0d want 6", pos); else n_pass++;
        n_total++; if (DONE !== 1'b1) $display("FAIL tog_done: got %b want 1", DONE); else n_pass++;
    endtask

    task automatic test_reset_abort();
        int edges, pos;
        do_reset();
        stim = '{8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        pulse_start();
        run_stream(1'b0, 12, edges, pos);
        n_total++; if (wr_data.size() !== 1) $display("FAIL abort_pre_writes: got %0d want 1", wr_data.size()); else n_pass++;
        n_total++; if (CORE_RSTn !== 1'b0) $display("FAIL abort_core_held: got %b want 0", CORE_RSTn); else n_pass++;
        RSTn = 1'b0;
        tick();
        RSTn = 1'b1;
        n_total++; if ({IN_READY, CORE_RSTn, DONE, ERR, I_MEM_CSN, I_MEM_WEN} !== 6'b000011) $display("FAIL abort_rst_outs: got %b want 000011", {IN_READY, CORE_RSTn, DONE, ERR, I_MEM_CSN, I_MEM_WEN}); else n_pass++;
        n_total++; if ({I_MEM_BE, I_MEM_ADDR, I_MEM_DOUT} !== 48'h0) $display("FAIL abort_rst_bus: got %h want 0", {I_MEM_BE, I_MEM_ADDR, I_MEM_DOUT}); else n_pass++;
        tick();
        wr_addr.delete();
        wr_data.delete();
        wr_be.delete();
        stim = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        pulse_start();
        run_stream(1'b0, 30, edges, pos);
        n_total++; if (edges !== 7) $display("FAIL reload_edge: got %0d want 7", edges); else n_pass++;
        n_total++; if (wr_data.size() !== 1) $display("FAIL reload_wr_count: got %0d want 1", wr_data.size()); else n_pass++;
        if (wr_data.size() == 1) begin
            n_total++; if (wr_data[0] !== 32'h44332211) $display("FAIL reload_data: got %h want 44332211", wr_data[0]); else n_pass++;
        end
        n_total++; if (DONE !== 1'b1) $display("FAIL reload_done: got %b want 1", DONE); else n_pass++;
    endtask

    task automatic test_run_passthrough();
        CORE_I_MEM_ADDR = 12'h0A4;
        CORE_I_MEM_CSN  = 1'b0;
        #1;
        n_total++; if (I_MEM_ADDR !== 12'h0A4) $display("FAIL run_addr: got %h want 0a4", I_MEM_ADDR); else n_pass++;
        n_total++; if ({I_MEM_CSN, I_MEM_WEN, I_MEM_BE} !== 6'b010000) $display("FAIL run_ctrl: got %b want 010000", {I_MEM_CSN, I_MEM_WEN, I_MEM_BE}); else n_pass++;
        CORE_I_MEM_ADDR = 12'h3FC;
        CORE_I_MEM_CSN  = 1'b1;
        #1;
        n_total++; if ({I_MEM_CSN, I_MEM_ADDR} !== 13'h13FC) $display("FAIL run_follow: got %h want 13fc", {I_MEM_CSN, I_MEM_ADDR}); else n_pass++;
        pulse_start();
        tick();
        n_total++; if ({DONE, CORE_RSTn, IN_READY} !== 3'b110) $display("FAIL run_start_ignored: got %b want 110", {DONE, CORE_RSTn, IN_READY}); else n_pass++;
        CORE_I_MEM_CSN = 1'b1;
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_zero_count();
        test_overflow();
        test_toggle_valid();
        test_reset_abort();
        test_run_passthrough();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning the I-memory capacity in 32-bit words.
REQ-002 SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port RSTn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port START  input  1  single-cycle request to begin a program load.
REQ-005 SHALL have port IN_VALID  input  1  byte-stream data valid.
REQ-006 SHALL have port IN_DATA  input  8  byte-stream payload.
REQ-007 SHALL have port IN_READY  output  1  loader accepts a byte; transfer occurs when IN_VALID and IN_READY are both 1.
REQ-008 SHALL have port CORE_I_MEM_CSN  input  1  core instruction-fetch chip select, active-low.
REQ-009 SHALL have port CORE_I_MEM_ADDR  input  12  core fetch byte address.
REQ-010 SHALL have port I_MEM_CSN  output  1  I-memory chip select, active-low.
REQ-011 SHALL have port I_MEM_WEN  output  1  I-memory write enable, active-low.
REQ-012 SHALL have port I_MEM_BE  output  4  I-memory byte enables.
REQ-013 SHALL have port I_MEM_ADDR  output  12  I-memory byte address, word-aligned.
REQ-014 SHALL have port I_MEM_DOUT  output  32  I-memory write data.
REQ-015 SHALL have port CORE_RSTn  output  1  core reset, active-low.
REQ-016 SHALL have port DONE  output  1  load complete; core running.
REQ-017 SHALL have port ERR  output  1  sticky load error.

Function
REQ-018 SHALL use states IDLE, HDR0, HDR1, DATA, WR, RUN, ERR.
REQ-019 IDLE: START=1 -> HDR0; IN_VALID ignored; no byte consumed.
REQ-020 IN_READY SHALL be 1 only in HDR0, HDR1 and DATA; while IN_READY=0, bytes are not consumed.
REQ-021 HDR0: on transfer, latch count[7:0] -> HDR1; HDR1: on transfer, latch count[15:8].
REQ-022 After HDR1: count=0 -> RUN; count>DEPTH -> ERR; otherwise -> DATA with word index 0 and lane 0.
REQ-023 DATA: each transfer fills the next byte lane, little-endian (first byte = bits 7:0); the 4th transfer -> WR.
REQ-024 WR: exactly one cycle with I_MEM_CSN=0, I_MEM_WEN=0, I_MEM_BE=4'b1111, I_MEM_ADDR = word index*4, I_MEM_DOUT = assembled word.
REQ-025 After WR: word index+1; if that was word count-1 -> RUN, otherwise -> DATA with lane 0.
REQ-026 With IN_VALID held high, each word costs 5 cycles (4 accepts + 1 WR).
REQ-027 CORE_RSTn and DONE SHALL rise the cycle after the final WR cycle; both are 0 in all other non-RUN states.
REQ-028 RUN: I_MEM_CSN=CORE_I_MEM_CSN and I_MEM_ADDR=CORE_I_MEM_ADDR combinationally; I_MEM_WEN=1; I_MEM_BE=0.
REQ-029 RUN is terminal until reset; START is ignored in RUN.
REQ-030 ERR: ERR=1, IN_READY=0, CORE_RSTn=0, memory idle; START is ignored; exit only by reset.
REQ-031 Outside WR and RUN: I_MEM_CSN=1, I_MEM_WEN=1, I_MEM_BE=0.
REQ-032 START in any state other than IDLE SHALL be ignored.

Reset
REQ-033 RSTn=0 at a rising edge SHALL force IDLE, IN_READY=0, I_MEM_CSN=1, I_MEM_WEN=1, I_MEM_BE=0, I_MEM_ADDR=0, I_MEM_DOUT=0, CORE_RSTn=0, DONE=0, ERR=0, and clear count, index and lane.
REQ-034 Reset during HDR/DATA/WR SHALL abort the load; words already written remain; the core stays in reset.

Structure
REQ-035 State encodings and the default DEPTH value SHALL live in the shared riscv_pkg header.
REQ-036 Byte-lane assembly (lane counter, 32-bit shift register, word-ready flag) SHALL be the sub-module prog_word_asm.

Verification
REQ-037 count=2, bytes 02 00 13 05 50 00 93 05 A0 00, IN_VALID steady -> writes 0x00500513 @0x000 and 0x00A00593 @0x004; CORE_RSTn=1 at cycle 13 after the first header byte.
REQ-038 Header 00 00 -> RUN the cycle after HDR1; no write strobes.
REQ-039 Header 01 04 (count 1025) -> ERR=1, IN_READY=0, CORE_RSTn=0; a subsequent START has no effect.
REQ-040 IN_VALID toggling 1,0 per cycle with count=1 -> same single write, 0xDDCCBBAA for bytes AA BB CC DD; no byte duplicated or lost.
REQ-041 RSTn pulsed low after 6 data bytes of count=3 -> IDLE, all outputs at reset values; a new START plus a full load completes normally.
REQ-042 In RUN, drive CORE_I_MEM_ADDR=0x0A4 and CORE_I_MEM_CSN=0 -> I_MEM_ADDR=0x0A4, I_MEM_CSN=0, I_MEM_WEN=1, I_MEM_BE=0 in the same cycle.
